// File: rtl/ascii_bit_word_assembler.sv
// Assembles ASCII '0'/'1' characters into WORD_W-bit words (MSB-first or LSB-first)
// and queues completed or line-terminated words in a first-word-fall-through FIFO.
module ascii_bit_word_assembler #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = $clog2(WORD_W + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   char_in,
  input  logic                         char_valid,
  output logic                         char_ready,
  input  logic                         reverse,
  output logic [WORD_W-1:0]            word_out,
  output logic [LEN_W-1:0]             word_len,
  output logic                         word_valid,
  input  logic                         word_ready,
  output logic                         bad_char,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WORD_W);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                rev_q, rev_d;
  logic                bad_q, bad_d;
  logic                ready_q, ready_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [WORD_W-1:0]   word_mem [DEPTH];
  logic [LEN_W-1:0]    len_mem  [DEPTH];

  logic                accept, is_bit, is_eol, rev_sel, pop, push;
  logic [LEN_W-1:0]    cnt_inc, bit_pos, push_len;
  logic [WORD_W-1:0]   bit_mask, set_word, push_word;

  assign accept  = char_valid && ready_q;
  assign is_bit  = (char_in[7:1] == 7'h18);
  assign is_eol  = (char_in == 8'h0A) || (char_in == 8'h0D);
  assign cnt_inc = cnt_q + 1'b1;

  // The first bit of a word uses the live reverse input; later bits use the latched copy.
  assign rev_sel  = (state_q == IDLE) ? reverse : rev_q;
  assign bit_pos  = rev_sel ? cnt_q : (FULL_LEN - 1'b1 - cnt_q);
  assign bit_mask = {{(WORD_W-1){1'b0}}, 1'b1} << bit_pos;
  assign set_word = shift_q | (char_in[0] ? bit_mask : '0);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rev_d     = rev_q;
    bad_d     = 1'b0;
    push      = 1'b0;
    push_word = set_word;
    push_len  = cnt_inc;
    if (accept) begin
      if (is_bit) begin
        case (state_q)
          IDLE: begin
            rev_d   = reverse;
            state_d = COLLECT;
          end
          default: state_d = COLLECT;
        endcase
        shift_d = set_word;
        cnt_d   = cnt_inc;
        if (cnt_inc == FULL_LEN) begin
          push      = 1'b1;
          push_word = set_word;
          push_len  = FULL_LEN;
          state_d   = IDLE;
          cnt_d     = '0;
          shift_d   = '0;
        end
      end else if (is_eol) begin
        case (state_q)
          COLLECT: begin
            push      = 1'b1;
            push_word = shift_q;
            push_len  = cnt_q;
            state_d   = IDLE;
            cnt_d     = '0;
            shift_d   = '0;
          end
          default: state_d = IDLE;
        endcase
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  // FIFO bookkeeping; push is never issued while full because char_ready is low then.
  assign pop = (count_q != '0) && word_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      rev_q    <= 1'b0;
      bad_q    <= 1'b0;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      rev_q    <= rev_d;
      bad_q    <= bad_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= push_word;
      len_mem[wr_ptr_q]  <= push_len;
    end
  end

  // Head entry is masked to zero when empty so stale storage never leaks out.
  assign word_valid = (count_q != '0);
  assign word_out   = word_valid ? word_mem[rd_ptr_q] : '0;
  assign word_len   = word_valid ? len_mem[rd_ptr_q]  : '0;
  assign fifo_count = count_q;
  assign char_ready = ready_q;
  assign bad_char   = bad_q;

endmodule

// File: tb/tb_ascii_bit_word_assembler.sv
// Directed table-driven bench for ascii_bit_word_assembler plus hand-written
// sequences for backpressure, same-edge push/pop, bad characters and mid-word reset.
module tb_ascii_bit_word_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       reverse;
  logic [7:0] word_out;
  logic [3:0] word_len;
  logic       word_valid;
  logic       word_ready;
  logic       bad_char;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ascii_bit_word_assembler #(.WORD_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .reverse    (reverse),
    .word_out   (word_out),
    .word_len   (word_len),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bad_char   (bad_char),
    .fifo_count (fifo_count)
  );

  typedef struct {
    string      chars;
    logic       rev;
    logic       push;
    logic [7:0] word;
    logic [3:0] len;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] bp_words [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int guard;
    guard = 0;
    @(negedge clk);
    char_in    = c;
    char_valid = 1'b1;
    while (!char_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=%0d required=<200", guard);
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_char(w[i] ? 8'h31 : 8'h30);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    reverse    = 1'b0;
    word_ready = 1'b0;

    vecs[0]  = '{chars:"10110000", rev:1'b0, push:1'b1, word:8'hB0, len:4'd8};
    vecs[1]  = '{chars:"10110000", rev:1'b1, push:1'b1, word:8'h0D, len:4'd8};
    vecs[2]  = '{chars:"111\n",    rev:1'b0, push:1'b1, word:8'hE0, len:4'd3};
    vecs[3]  = '{chars:"\r",       rev:1'b0, push:1'b0, word:8'h00, len:4'd0};
    vecs[4]  = '{chars:"\n",       rev:1'b1, push:1'b0, word:8'h00, len:4'd0};
    vecs[5]  = '{chars:"0101\r",   rev:1'b1, push:1'b1, word:8'h0A, len:4'd4};
    vecs[6]  = '{chars:"00000001", rev:1'b0, push:1'b1, word:8'h01, len:4'd8};
    vecs[7]  = '{chars:"00000001", rev:1'b1, push:1'b1, word:8'h80, len:4'd8};
    vecs[8]  = '{chars:"1\n",      rev:1'b1, push:1'b1, word:8'h01, len:4'd1};
    vecs[9]  = '{chars:"1\r",      rev:1'b0, push:1'b1, word:8'h80, len:4'd1};
    vecs[10] = '{chars:"11111111", rev:1'b1, push:1'b1, word:8'hFF, len:4'd8};
    bp_words = '{8'h81, 8'h42, 8'h24, 8'h18};

    // Reset state
    #12;
    chk("rst_word_out",   32'(word_out),   0);
    chk("rst_word_len",   32'(word_len),   0);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_bad_char",   32'(bad_char),   0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_char_ready", 32'(char_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_char_ready", 32'(char_ready), 1);

    // Table of single-word transactions with the consumer always ready
    for (int k = 0; k < 11; k++) begin
      reverse    = vecs[k].rev;
      word_ready = 1'b1;
      for (int i = 0; i < vecs[k].chars.len(); i++) send_char(vecs[k].chars[i]);
      if (vecs[k].push) begin
        chk($sformatf("vec%0d_valid", k), 32'(word_valid), 1);
        chk($sformatf("vec%0d_word", k),  32'(word_out),   32'(vecs[k].word));
        chk($sformatf("vec%0d_len", k),   32'(word_len),   32'(vecs[k].len));
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_one_cycle", k), 32'(word_valid), 0);
      end else begin
        chk($sformatf("vec%0d_no_push", k), 32'(word_valid), 0);
        chk($sformatf("vec%0d_count", k),   32'(fifo_count), 0);
      end
    end

    // Push and pop on the same edge
    word_ready = 1'b0;
    reverse    = 1'b0;
    send_word(8'hA5);
    for (int i = 7; i >= 1; i--) send_char(i inside {2, 3, 4, 5} ? 8'h31 : 8'h30);
    chk("pp_count_before", 32'(fifo_count), 1);
    chk("pp_head_before",  32'(word_out),   'hA5);
    word_ready = 1'b1;
    send_char(8'h30);
    chk("pp_count_after", 32'(fifo_count), 1);
    chk("pp_head_after",  32'(word_out),   'h3C);
    @(posedge clk);
    #1;
    chk("pp_drained", 32'(word_valid), 0);
    word_ready = 1'b0;

    // Backpressure: fill the FIFO, hold off a character, then drain in order
    for (int k = 0; k < 4; k++) send_word(bp_words[k]);
    chk("bp_full_count", 32'(fifo_count), 4);
    chk("bp_full_ready", 32'(char_ready), 0);
    @(negedge clk);
    char_in    = 8'h31;
    char_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_ready", 32'(char_ready), 0);
    chk("bp_held_count", 32'(fifo_count), 4);
    char_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_valid%0d", k), 32'(word_valid), 1);
      chk($sformatf("bp_word%0d", k),  32'(word_out),   32'(bp_words[k]));
      chk($sformatf("bp_len%0d", k),   32'(word_len),   8);
      word_ready = 1'b1;
      @(posedge clk);
      #1;
      word_ready = 1'b0;
      if (k == 0) chk("bp_ready_after_pop", 32'(char_ready), 1);
    end
    chk("bp_empty_count", 32'(fifo_count), 0);
    chk("bp_empty_valid", 32'(word_valid), 0);
    send_word(8'hFF);
    chk("bp_fifth_word",  32'(word_out),   'hFF);
    chk("bp_fifth_count", 32'(fifo_count), 1);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    chk("bp_final_count", 32'(fifo_count), 0);

    // Bad character mid-word; reverse changes mid-word and must not matter
    reverse = 1'b0;
    send_char(8'h31);
    reverse = 1'b1;
    send_char(8'h30);
    send_char(8'h31);
    send_char(8'h78);
    chk("bad_pulse",       32'(bad_char),   1);
    chk("bad_no_push",     32'(fifo_count), 0);
    @(posedge clk);
    #1;
    chk("bad_pulse_end",   32'(bad_char),   0);
    send_char(8'h31);
    send_char(8'h30);
    send_char(8'h30);
    send_char(8'h31);
    send_char(8'h31);
    chk("bad_word",        32'(word_out),   'hB3);
    chk("bad_len",         32'(word_len),   8);
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    chk("bad_drained",     32'(fifo_count), 0);

    // Reset mid-word with two words queued
    reverse = 1'b0;
    send_word(8'h0F);
    send_word(8'hF0);
    send_char(8'h31);
    send_char(8'h31);
    send_char(8'h30);
    send_char(8'h30);
    send_char(8'h31);
    chk("mr_count_before", 32'(fifo_count), 2);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_word_valid", 32'(word_valid), 0);
    chk("mr_fifo_count", 32'(fifo_count), 0);
    chk("mr_word_out",   32'(word_out),   0);
    chk("mr_word_len",   32'(word_len),   0);
    chk("mr_char_ready", 32'(char_ready), 0);
    chk("mr_bad_char",   32'(bad_char),   0);
    @(negedge clk);
    reset      = 1'b1;
    word_ready = 1'b1;
    send_word(8'h35);
    chk("mr_fresh_valid", 32'(word_valid), 1);
    chk("mr_fresh_word",  32'(word_out),   'h35);
    chk("mr_fresh_len",   32'(word_len),   8);
    @(posedge clk);
    #1;
    chk("mr_fresh_popped", 32'(word_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
